// File: rtl/line_mem_responder_if.sv
// Cache-side line memory bus: one request in flight, fixed-latency completion.
interface line_mem_responder_if;
    // enable is the request valid; it is taken only while busy is low, and the
    // transaction ends with a one-cycle ack (read data valid on rdata from then on).
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         enable;
    logic         write;
    logic         ack;
    logic [255:0] rdata;
    logic         busy;

    modport master (output addr, wdata, enable, write, input ack, rdata, busy);
    modport slave  (input addr, wdata, enable, write, output ack, rdata, busy);
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 256-bit line memory: accept a request, wait LATENCY edges, then
// commit the write or capture the read line and pulse ack_o for one cycle.
module line_mem_responder #(
    parameter int MEM_LINES = 512,
    parameter int LATENCY   = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [8:0]     line_q, line_d;
    logic [255:0]   wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           ack_q, ack_d;
    logic [255:0]   rdata_q;
    logic           complete;

    reg [255:0] memory [0:MEM_LINES-1];

    // Only the line index bits of the byte address select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:14], addr_i[4:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        ack_d    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    line_d  = addr_i[13:5];
                    wdata_d = data_i;
                    wr_d    = write_i;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    complete = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            if (complete && !wr_q) begin
                rdata_q <= memory[line_q];
            end
        end
    end

    // The array has no reset so contents survive rst_i; an aborted write never commits.
    always_ff @(posedge clk_i) begin
        if (rst_i && complete && wr_q) begin
            memory[line_q] <= wdata_q;
        end
    end

    assign ack_o       = ack_q;
    assign data_o      = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LINES, default 512, number of 256-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 10, clock edges from request acceptance to access completion; legal range 2..255.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port addr_i  input  32  byte address; line index = addr_i[13:5], all other bits ignored.
REQ-006 SHALL have port data_i  input  256  write line data.
REQ-007 SHALL have port enable_i  input  1  request valid from the cache-side initiator.
REQ-008 SHALL have port write_i  input  1  1 = write line, 0 = read line; qualified by enable_i.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data.
REQ-011 SHALL have port busy_o  output  1  high in WAIT and ACK states.

Function
REQ-012 SHALL implement states IDLE, WAIT, ACK, held in a registered state variable.
REQ-013 In IDLE, enable_i=1 at a rising edge SHALL latch line index, data_i and write_i, clear the latency counter to 0, and enter WAIT.
REQ-014 In IDLE, enable_i=0 SHALL keep the state in IDLE; write_i and data_i are ignored.
REQ-015 In WAIT, the counter SHALL increment by 1 per edge; at the edge where the counter equals LATENCY-1, the access SHALL complete and the state SHALL enter ACK.
REQ-016 At completion, a latched write SHALL store the latched data into the latched line; a latched read SHALL load that line into data_o.
REQ-017 ack_o SHALL be registered and high for exactly the one cycle spent in ACK, i.e. the cycle following edge E0+LATENCY, where E0 is the acceptance edge.
REQ-018 ACK SHALL unconditionally return to IDLE on the next edge; a new request SHALL be accepted no earlier than the edge after that, giving at least one IDLE cycle between transactions.
REQ-019 Changes to addr_i, data_i, write_i or enable_i during WAIT or ACK SHALL have no effect on the in-flight transaction.
REQ-020 data_o SHALL hold its value except on read completion; write transactions SHALL leave data_o unchanged.
REQ-021 Line index wrap-around: addresses differing only above bit 13 SHALL alias to the same line.
REQ-022 The memory array SHALL be a plain reg array, named memory, that hierarchical preload/dump by the bench can access; the block SHALL NOT initialize it.

Reset
REQ-023 With rst_i=0 at an edge: state SHALL become IDLE, counter 0, ack_o 0, data_o 0, busy_o 0.
REQ-024 Reset during WAIT SHALL abort the transaction with no memory write and no ack_o pulse.
REQ-025 Reset SHALL NOT modify memory array contents.
REQ-026 After rst_i returns to 1, a request present at the first edge SHALL be accepted normally.

Verification
REQ-027 Preload memory[0]=256'h0000_1111_..._FFFF; read addr 0x0000 accepted at edge 0 -> ack_o high only between edges 10 and 11, data_o equals preload, busy_o high edges 0..10.
REQ-028 Write addr 0x0020, data 256'hECFA repeated, then read addr 0x0020 -> memory[1] updated at completion edge only; read returns 256'hECFA... and data_o unchanged during the write.
REQ-029 Read addr 0x4040 -> returns memory[2] (alias via bits [13:5]).
REQ-030 Write accepted, rst_i=0 at edge 5 of WAIT -> no ack_o, memory line unchanged, all outputs 0; next request completes with full LATENCY.
REQ-031 enable_i held high continuously across two back-to-back reads of lines 3 and 16 -> second accepted at the edge after ACK exits; exactly one ack_o per transaction; input changes mid-WAIT ignored.
REQ-032 LATENCY=2 build: read accepted at edge 0 -> ack_o high between edges 2 and 3.
